// File: rtl/williams_input_pkg.sv
// Shared joystick bit map, coin FSM encoding and direction helper for williams_input_cond.
package williams_input_pkg;

    localparam int JOY_W     = 13;
    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_FIRE_A = 4;
    localparam int JB_FIRE_B = 5;
    localparam int JB_FIRE_C = 6;
    localparam int JB_FIRE_D = 7;
    localparam int JB_FIRE_E = 8;
    localparam int JB_FIRE_F = 9;
    localparam int JB_START1 = 10;
    localparam int JB_START2 = 11;
    localparam int JB_COIN   = 12;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_REL
    } coin_state_t;

    // Single direction by priority up > down > left > right; bit order {up, down, left, right}.
    function automatic logic [3:0] dir_pick(input logic [3:0] d);
        logic [3:0] r;
        r = 4'b0000;
        if (d[3])      r = 4'b1000;
        else if (d[2]) r = 4'b0100;
        else if (d[1]) r = 4'b0010;
        else if (d[0]) r = 4'b0001;
        return r;
    endfunction

endpackage

// File: rtl/williams_input_debounce.sv
// Sampled shift-history debouncer: a bit changes only when DEB_SAMPLES consecutive samples agree.
module input_debounce #(
    parameter int unsigned WIDTH       = 13,
    parameter int unsigned DEB_TICK    = 1024,
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_strobe
);

    localparam int unsigned   TW        = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DEB_TICK - 1);

    logic [TW-1:0]                      r_tick;
    logic [WIDTH-1:0][DEB_SAMPLES-1:0] r_hist;
    logic [WIDTH-1:0][DEB_SAMPLES-1:0] w_hist_next;
    logic [WIDTH-1:0]                   r_dout;
    logic [WIDTH-1:0]                   w_dout_next;
    logic                               w_strobe;

    assign w_strobe = (r_tick == TICK_LAST);
    assign o_strobe = w_strobe;
    assign o_dout   = r_dout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick <= '0;
        end else if (w_strobe) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_comb begin
        w_hist_next = '0;
        w_dout_next = r_dout;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_hist_next[i] = {r_hist[i][DEB_SAMPLES-2:0], i_din[i]};
            if (&w_hist_next[i]) begin
                w_dout_next[i] = 1'b1;
            end else if (~|w_hist_next[i]) begin
                w_dout_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
            r_dout <= '0;
        end else if (w_strobe) begin
            r_hist <= w_hist_next;
            r_dout <= w_dout_next;
        end
    end

endmodule

// File: rtl/williams_input_cond.sv
// Joystick conditioning: debounce, opposing cancel, 4-way restriction and frame-stretched coin.
// Optional autofire on fire A is built only when WILLIAMS_AUTOFIRE_EN is defined.
module williams_input_cond
    import williams_input_pkg::*;
#(
    parameter int unsigned DEB_TICK    = 1024,
    parameter int unsigned DEB_SAMPLES = 3,
    parameter int unsigned COIN_FRAMES = 4,
    parameter int unsigned AF_FRAMES   = 3
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             vs,
    input  logic [JOY_W-1:0] joy_in,
    input  logic             four_way,
    input  logic             af_en,
    output logic [JOY_W-1:0] joy_out
);

    localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);

    logic [JOY_W-1:0]    w_deb;
    logic                w_strobe;
    logic                r_vs;
    logic                r_vs_d;
    logic                w_frame_tick;
    logic [3:0]          w_dir_c;
    logic [3:0]          w_dir_held;
    logic [3:0]          w_dir_next;
    logic                w_fire_a;
    logic [JB_START2:0]  r_joy_lo;
    coin_state_t         r_coin_state;
    logic [3:0]          r_coin_cnt;
    logic                r_coin_out;
    logic                r_coin_prev;
    logic                r_coin_arm;
    logic                w_coin_rise;

    input_debounce #(
        .WIDTH       (JOY_W),
        .DEB_TICK    (DEB_TICK),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) u_debounce (
        .i_clk    (clk_sys),
        .i_rst    (reset),
        .i_din    (joy_in),
        .o_dout   (w_deb),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_vs   <= vs;
            r_vs_d <= r_vs;
        end
    end

    assign w_frame_tick = r_vs & ~r_vs_d;

    // Keep the previous 4-way direction while it stays held, otherwise pick by priority.
    always_comb begin
        w_dir_c = w_deb[JB_UP:JB_RIGHT];
        if (w_deb[JB_LEFT] && w_deb[JB_RIGHT]) begin
            w_dir_c[JB_LEFT:JB_RIGHT] = 2'b00;
        end
        if (w_deb[JB_UP] && w_deb[JB_DOWN]) begin
            w_dir_c[JB_UP:JB_DOWN] = 2'b00;
        end
        w_dir_held = r_joy_lo[JB_UP:JB_RIGHT] & w_dir_c;
        w_dir_next = w_dir_c;
        if (four_way) begin
            w_dir_next = (|w_dir_held) ? dir_pick(w_dir_held) : dir_pick(w_dir_c);
        end
    end

`ifdef WILLIAMS_AUTOFIRE_EN
    localparam logic [3:0] AF_LAST = 4'(AF_FRAMES - 1);

    logic       r_af_on;
    logic       r_af_lvl;
    logic [3:0] r_af_cnt;
    logic       w_af_on_d;
    logic       w_af_lvl_d;
    logic [3:0] w_af_cnt_d;
    logic       w_af_active;

    assign w_af_active = af_en & w_deb[JB_FIRE_A];

    always_comb begin
        w_af_on_d  = r_af_on;
        w_af_lvl_d = r_af_lvl;
        w_af_cnt_d = r_af_cnt;
        if (!w_af_active) begin
            w_af_on_d  = 1'b0;
            w_af_lvl_d = 1'b0;
            w_af_cnt_d = 4'd0;
        end else if (!r_af_on) begin
            w_af_on_d  = 1'b1;
            w_af_lvl_d = 1'b1;
            w_af_cnt_d = 4'd0;
        end else if (w_frame_tick) begin
            if (r_af_cnt >= AF_LAST) begin
                w_af_cnt_d = 4'd0;
                w_af_lvl_d = ~r_af_lvl;
            end else begin
                w_af_cnt_d = r_af_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_af_on  <= 1'b0;
            r_af_lvl <= 1'b0;
            r_af_cnt <= 4'd0;
        end else begin
            r_af_on  <= w_af_on_d;
            r_af_lvl <= w_af_lvl_d;
            r_af_cnt <= w_af_cnt_d;
        end
    end

    assign w_fire_a = w_af_active ? w_af_lvl_d : w_deb[JB_FIRE_A];
`else
    logic w_unused_af;
    assign w_unused_af = af_en | (AF_FRAMES == 0);
    assign w_fire_a    = w_deb[JB_FIRE_A];
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_joy_lo <= '0;
        end else begin
            r_joy_lo <= {w_deb[JB_START2:JB_FIRE_B], w_fire_a, w_dir_next};
        end
    end

    // Arming needs a raw low sample, so a coin held across reset cannot fire a pulse.
    assign w_coin_rise = w_deb[JB_COIN] & ~r_coin_prev & r_coin_arm;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_coin_state <= IDLE;
            r_coin_cnt   <= 4'd0;
            r_coin_out   <= 1'b0;
            r_coin_prev  <= 1'b0;
            r_coin_arm   <= 1'b0;
        end else begin
            r_coin_prev <= w_deb[JB_COIN];
            if (w_strobe && !joy_in[JB_COIN]) begin
                r_coin_arm <= 1'b1;
            end
            case (r_coin_state)
                IDLE: begin
                    if (w_coin_rise) begin
                        r_coin_state <= PULSE;
                        r_coin_cnt   <= COIN_LOAD;
                        r_coin_out   <= 1'b1;
                    end
                end
                PULSE: begin
                    if (w_frame_tick) begin
                        if (r_coin_cnt <= 4'd1) begin
                            r_coin_state <= WAIT_REL;
                            r_coin_cnt   <= 4'd0;
                            r_coin_out   <= 1'b0;
                        end else begin
                            r_coin_cnt <= r_coin_cnt - 4'd1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (!w_deb[JB_COIN]) begin
                        r_coin_state <= IDLE;
                    end
                end
                default: begin
                    r_coin_state <= IDLE;
                    r_coin_out   <= 1'b0;
                end
            endcase
        end
    end

    assign joy_out = {r_coin_out, r_joy_lo};

endmodule

// File: tb/tb_williams_input_cond.sv
// Directed bench for williams_input_cond with a queue of expected outputs popped at check points.
module tb_williams_input_cond;

    localparam logic [12:0] ALL  = 13'h1FFF;
    localparam logic [12:0] DIRS = 13'h000F;
    localparam logic [12:0] COIN = 13'h1000;
    localparam logic [12:0] FA   = 13'h0010;

    logic        clk;
    logic        reset;
    logic        vs;
    logic [12:0] joy_in;
    logic        four_way;
    logic        af_en;
    logic [12:0] joy_out;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       tag;
        logic [12:0] mask;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    logic [7:0] af_pat;

    williams_input_cond #(
        .DEB_TICK    (4),
        .DEB_SAMPLES (3),
        .COIN_FRAMES (4),
        .AF_FRAMES   (2)
    ) dut (
        .clk_sys  (clk),
        .reset    (reset),
        .vs       (vs),
        .joy_in   (joy_in),
        .four_way (four_way),
        .af_en    (af_en),
        .joy_out  (joy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [12:0] mask, input logic [12:0] val);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [12:0] got;
        e   = sb.pop_front();
        got = joy_out & e.mask;
        n_cmp++;
        assert (got === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, got, e.val);
        end
    endtask

    task automatic check();
        @(negedge clk);
        check_now();
    endtask

    task automatic wait_until(input logic [12:0] mask, input logic [12:0] val, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            cyc(1);
            hit = ((joy_out & mask) == val);
        end
    endtask

    task automatic frame();
        vs = 1'b1;
        cyc(2);
        vs = 1'b0;
        cyc(18);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        vs       = 1'b0;
        joy_in   = '0;
        four_way = 1'b0;
        af_en    = 1'b0;
`ifdef WILLIAMS_AUTOFIRE_EN
        af_pat = 8'b0011_0011;
`else
        af_pat = 8'b1111_1111;
`endif

        cyc(3);
        sb_push("reset_hold", ALL, 13'h0000);
        check();
        cyc(1);
        reset = 1'b0;
        cyc(2);
        sb_push("reset_release", ALL, 13'h0000);
        check();
        cyc(1);

        // Right toggles every 5 cycles against a 4-cycle sample period: never 3 equal samples.
        for (int i = 0; i < 12; i++) begin
            joy_in[0] = ~joy_in[0];
            cyc(4);
            sb_push($sformatf("bounce_reject%0d", i), 13'h0001, 13'h0000);
            check();
            cyc(1);
        end
        joy_in[0] = 1'b1;
        wait_until(13'h0001, 13'h0001, 14);
        sb_push("bounce_settle", 13'h0001, 13'h0001);
        check();
        joy_in = '0;
        cyc(20);

        joy_in[1:0] = 2'b11;
        cyc(20);
        sb_push("cancel_lr", DIRS, 13'h0000);
        check();
        joy_in[0] = 1'b0;
        cyc(20);
        sb_push("cancel_release_right", DIRS, 13'h0002);
        check();
        joy_in[3:0] = 4'b1110;
        cyc(20);
        sb_push("cancel_ud", DIRS, 13'h0002);
        check();
        joy_in = '0;
        cyc(20);
        joy_in[3:0] = 4'b1001;
        cyc(20);
        sb_push("eight_way_diag", DIRS, 13'h0009);
        check();

        joy_in   = '0;
        four_way = 1'b1;
        cyc(20);
        joy_in[3] = 1'b1;
        cyc(20);
        sb_push("4way_up", DIRS, 13'h0008);
        check();
        joy_in[0] = 1'b1;
        cyc(20);
        sb_push("4way_hold_up", DIRS, 13'h0008);
        check();
        joy_in[3] = 1'b0;
        cyc(20);
        sb_push("4way_right", DIRS, 13'h0001);
        check();
        joy_in = '0;
        cyc(20);
        sb_push("4way_none", DIRS, 13'h0000);
        check();
        joy_in[2:1] = 2'b11;
        cyc(20);
        sb_push("4way_priority", DIRS, 13'h0004);
        check();
        cyc(1);
        four_way = 1'b0;
        cyc(1);
        sb_push("4way_off_next_clk", DIRS, 13'h0006);
        check();
        joy_in = '0;
        cyc(20);

        joy_in[11:5] = 7'b1011001;
        cyc(20);
        sb_push("passthrough", 13'h0FE0, {1'b0, 7'b1011001, 5'b00000});
        check();
        joy_in = '0;
        cyc(20);

        af_en     = 1'b1;
        joy_in[4] = 1'b1;
        wait_until(FA, FA, 20);
        for (int k = 0; k < 8; k++) begin
            sb_push($sformatf("fire_a_frame%0d", k), FA, af_pat[k] ? FA : 13'h0000);
            check();
            frame();
        end
        joy_in[4] = 1'b0;
        cyc(20);
        sb_push("fire_a_release", FA, 13'h0000);
        check();
        af_en = 1'b0;
        cyc(1);

        joy_in[12] = 1'b1;
        wait_until(COIN, COIN, 30);
        sb_push("coin2_rise", COIN, COIN);
        check();
        for (int k = 1; k <= 6; k++) begin
            frame();
            sb_push($sformatf("coin2_frame%0d", k), COIN, (k < 4) ? COIN : 13'h0000);
            check();
            if (k == 2) joy_in[12] = 1'b0;
        end
        cyc(30);

        joy_in[12] = 1'b1;
        wait_until(COIN, COIN, 30);
        sb_push("coin10_rise", COIN, COIN);
        check();
        for (int k = 1; k <= 10; k++) begin
            frame();
            sb_push($sformatf("coin10_frame%0d", k), COIN, (k < 4) ? COIN : 13'h0000);
            check();
        end
        joy_in[12] = 1'b0;
        cyc(30);
        sb_push("coin10_after_release", COIN, 13'h0000);
        check();
        cyc(1);

        joy_in[12] = 1'b1;
        wait_until(COIN, COIN, 30);
        frame();
        frame();
        sb_push("coin_mid_pulse", COIN, COIN);
        check();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb_push("reset_async_drop", ALL, 13'h0000);
        check_now();
        cyc(2);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            frame();
            sb_push($sformatf("held_through_reset%0d", k), COIN, 13'h0000);
            check();
        end
        joy_in[12] = 1'b0;
        cyc(30);
        sb_push("released_after_reset", COIN, 13'h0000);
        check();
        cyc(1);
        joy_in[12] = 1'b1;
        wait_until(COIN, COIN, 30);
        sb_push("coin_repress", COIN, COIN);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
